// File: rtl/serial_compare_controller.sv
// serial_compare_controller
//   Sequencer for an external MSB-first serial magnitude comparator. Accepts an
//   operand pair on a valid/ready handshake and clears the comparator. It then
//   serializes both words MSB-first and returns the comparator's sampled one-hot
//   result on a valid/ready result handshake. With EARLY_EXIT=1, serialization
//   stops at the first differing bit.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_a, in_b operands
//   abort                 synchronous abort, highest priority
//   ser_clr, ser_a, ser_b comparator clear and serial bit lines
//   cmp_lt/eq/gt          comparator result for the bit presented this cycle
//   out_valid/out_ready   result handshake; out_lt/eq/gt result, out_bits count
//   busy                  controller not idle
module serial_compare_controller #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic                       abort,
    output logic                       ser_clr,
    output logic                       ser_a,
    output logic                       ser_b,
    input  logic                       cmp_lt,
    input  logic                       cmp_eq,
    input  logic                       cmp_gt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_lt,
    output logic                       out_eq,
    output logic                       out_gt,
    output logic [$clog2(WIDTH+1)-1:0] out_bits,
    output logic                       busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned BW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StClear, StShift, StDone} state_t;

    state_t         state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= StIdle;
            sh_a     <= '0;
            sh_b     <= '0;
            cnt      <= '0;
            out_lt   <= 1'b0;
            out_eq   <= 1'b0;
            out_gt   <= 1'b0;
            out_bits <= '0;
        end else if (abort) begin
            // Abort wins over everything, including an accept in idle.
            state    <= StIdle;
            out_lt   <= 1'b0;
            out_eq   <= 1'b0;
            out_gt   <= 1'b0;
            out_bits <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        sh_a  <= in_a;
                        sh_b  <= in_b;
                        cnt   <= CW'(WIDTH - 1);
                        state <= StClear;
                    end
                end
                StClear: begin
                    state <= StShift;
                end
                StShift: begin
                    sh_a <= {sh_a[WIDTH-2:0], 1'b0};
                    sh_b <= {sh_b[WIDTH-2:0], 1'b0};
                    cnt  <= cnt - CW'(1);
                    if (cnt == '0 || (EARLY_EXIT && !cmp_eq)) begin
                        // Sampled as-is; a non-one-hot comparator is not corrected.
                        out_lt   <= cmp_lt;
                        out_eq   <= cmp_eq;
                        out_gt   <= cmp_gt;
                        // Bits driven so far, including the current one.
                        out_bits <= BW'(WIDTH) - BW'(cnt);
                        state    <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == StIdle);
        busy      = (state != StIdle);
        out_valid = (state == StDone);
        // Abort also clears the comparator, except when nothing is in flight.
        ser_clr   = (state == StClear) || (abort && state != StIdle);
        ser_a     = (state == StShift) && sh_a[WIDTH-1];
        ser_b     = (state == StShift) && sh_b[WIDTH-1];
    end

    cmp_onehot_a: assert property (@(posedge clk) disable iff (!rst)
        (state == StShift) |-> $onehot({cmp_lt, cmp_eq, cmp_gt}));

endmodule
